// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared definitions for the registered decode stage: opcode and ALU encodings,
// the control-word bundle and the fixed NOP / illegal words.
package ctrl_pkg;

    localparam int OPC_W    = 4;
    localparam int FN_W     = 2;
    localparam int CW_ALU_W = 3;

    localparam logic [OPC_W-1:0] OP_SUM  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUMI = 4'b0001;
    localparam logic [OPC_W-1:0] OP_RES  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_RESI = 4'b0011;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b0110;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_COMP = 4'b1000;
    localparam logic [OPC_W-1:0] OP_STO  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_VECH = 4'b1010;
    localparam logic [OPC_W-1:0] OP_OBT  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_CAR  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_CARI = 4'b1110;
    localparam logic [OPC_W-1:0] OP_ALMB = 4'b1111;

    localparam logic [FN_W-1:0] F_IMM = 2'b01;
    localparam logic [FN_W-1:0] F_NOP = 2'b11;

    localparam logic [CW_ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [CW_ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [CW_ALU_W-1:0] ALU_MUL  = 3'b010;
    localparam logic [CW_ALU_W-1:0] ALU_AND  = 3'b011;
    localparam logic [CW_ALU_W-1:0] ALU_OR   = 3'b100;
    localparam logic [CW_ALU_W-1:0] ALU_PASS = 3'b101;

    typedef struct packed {
        logic                sel_a;
        logic                sel_b;
        logic                sel_ext;
        logic                sel_res;
        logic                sel_dat;
        logic                sel_c;
        logic [1:0]          selop_a;
        logic [1:0]          selop_b;
        logic [CW_ALU_W-1:0] alu_ctrl;
        logic                we_mem;
        logic                we_c_aux;
        logic                we_v;
        logic                compara;
        logic                suma_resta;
        logic                salto;
        logic                prohib;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP     = '0;
    localparam ctrl_word_t CW_ILLEGAL = '{prohib: 1'b1, default: '0};

    // Loads are the only instructions whose result arrives late (load-use hazard source).
    function automatic logic is_load(input logic [OPC_W-1:0] op);
        return (op == OP_OBT) || (op == OP_CAR) || (op == OP_CARI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational OPCODE/F to control-word decoder with illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [FN_W-1:0]  f,
    output ctrl_word_t       word,
    output logic             illegal
);

    ctrl_word_t word_s;
    logic       illegal_s;

    // Decode table; NOP (SUM with F=11) yields the all-zero word, undefined opcodes the prohibit word.
    always_comb begin
        word_s    = CW_NOP;
        illegal_s = 1'b0;
        if ((opcode == OP_SUM) && (f == F_NOP)) begin
            word_s = CW_NOP;
        end else begin
            case (opcode)
                OP_SUM, OP_SUMI: begin
                    word_s.alu_ctrl = ALU_ADD;
                    word_s.we_v     = 1'b1;
                end
                OP_RES, OP_RESI: begin
                    word_s.alu_ctrl   = ALU_SUB;
                    word_s.suma_resta = 1'b1;
                    word_s.we_v       = 1'b1;
                end
                OP_MUL: begin
                    word_s.alu_ctrl = ALU_MUL;
                    word_s.sel_res  = 1'b1;
                    word_s.we_v     = 1'b1;
                end
                OP_AND: begin
                    word_s.alu_ctrl = ALU_AND;
                    word_s.we_v     = 1'b1;
                end
                OP_OR: begin
                    word_s.alu_ctrl = ALU_OR;
                    word_s.we_v     = 1'b1;
                end
                OP_MOV: begin
                    word_s.alu_ctrl = ALU_PASS;
                    word_s.selop_a  = 2'b10;
                    word_s.we_v     = 1'b1;
                end
                OP_COMP: begin
                    word_s.alu_ctrl   = ALU_SUB;
                    word_s.suma_resta = 1'b1;
                    word_s.compara    = 1'b1;
                    word_s.we_c_aux   = 1'b1;
                end
                OP_STO: begin
                    word_s.we_mem = 1'b1;
                    word_s.sel_a  = 1'b1;
                    word_s.sel_b  = 1'b1;
                end
                OP_VECH: begin
                    word_s.salto   = 1'b1;
                    word_s.selop_a = 2'b01;
                end
                OP_OBT, OP_CAR: begin
                    word_s.sel_dat = 1'b1;
                    word_s.sel_a   = 1'b1;
                    word_s.we_v    = 1'b1;
                end
                OP_CARI: begin
                    word_s.sel_dat = 1'b1;
                    word_s.sel_a   = 1'b1;
                    word_s.sel_c   = 1'b1;
                    word_s.we_v    = 1'b1;
                end
                OP_ALMB: begin
                    word_s.we_mem = 1'b1;
                    word_s.sel_a  = 1'b1;
                    word_s.sel_b  = 1'b1;
                    word_s.sel_c  = 1'b1;
                end
                default: begin
                    word_s    = CW_ILLEGAL;
                    illegal_s = 1'b1;
                end
            endcase
            if (!illegal_s) begin
                word_s.sel_ext = (f == F_IMM);
                word_s.selop_b = (f == F_IMM) ? 2'b01 : 2'b00;
            end else begin
                word_s.sel_ext = 1'b0;
                word_s.selop_b = 2'b00;
            end
        end
    end

    assign word    = word_s;
    assign illegal = illegal_s;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// MUL occupancy stall, load-use bubble, branch flush and output register.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int F_W     = 2,
    parameter int ALU_W   = 3,
    parameter int RA_W    = 4,
    parameter int MUL_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [OP_W-1:0]  OPCODE,
    input  logic [F_W-1:0]   F,
    input  logic [RA_W-1:0]  RD,
    input  logic [RA_W-1:0]  RS1,
    input  logic [RA_W-1:0]  RS2,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [RA_W-1:0]  RD_Q,
    output logic             SEL_A,
    output logic             SEL_B,
    output logic             SEL_EXT,
    output logic             SEL_RES,
    output logic             SEL_DAT,
    output logic             SEL_C,
    output logic [1:0]       SELOP_A,
    output logic [1:0]       SELOP_B,
    output logic [ALU_W-1:0] ALU_CTRL,
    output logic             WE_MEM,
    output logic             WE_C_AUX,
    output logic             WE_V,
    output logic             COMPARA,
    output logic             SUMA_RESTA,
    output logic             SALTO,
    output logic             PROHIB,
    output logic             ILLEGAL,
    output logic             MUL_BUSY
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [OPC_W-1:0] op_s;
    logic [FN_W-1:0]  f_s;
    ctrl_word_t       dec_word_s;
    logic             dec_illegal_s;
    logic             mul_busy_s;
    logic             hz_stall_s;
    logic             in_ready_s;
    logic             accept_s;

    ctrl_word_t       word_r;
    logic [RA_W-1:0]  rd_r;
    logic             illegal_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] mul_cnt_r;
    logic             ld_flag_r;
    logic [RA_W-1:0]  ld_rd_r;

    assign op_s = OPC_W'(OPCODE);
    assign f_s  = FN_W'(F);

    ctrl_decode u_decode (
        .opcode  (op_s),
        .f       (f_s),
        .word    (dec_word_s),
        .illegal (dec_illegal_s)
    );

    assign mul_busy_s = (mul_cnt_r != {CNT_W{1'b0}});
    assign hz_stall_s = ld_flag_r & IN_VALID & (ld_rd_r != {RA_W{1'b0}}) &
                        ((RS1 == ld_rd_r) | (RS2 == ld_rd_r));
    assign in_ready_s = RST_N & ~FLUSH & ~mul_busy_s & ~hz_stall_s & (~out_valid_r | OUT_READY);
    assign accept_s   = IN_VALID & in_ready_s;

    // Output register: load on accept, drop valid when consumed, flush kills the held word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_r      <= CW_NOP;
            rd_r        <= {RA_W{1'b0}};
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (FLUSH) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            word_r      <= dec_word_s;
            rd_r        <= RD;
            illegal_r   <= dec_illegal_s;
            out_valid_r <= 1'b1;
        end else if (OUT_READY) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // MUL occupancy: blocks fetch for MUL_LAT-1 cycles after a MUL is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mul_cnt_r <= {CNT_W{1'b0}};
        end else if (FLUSH) begin
            mul_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && (op_s == OP_MUL)) begin
            mul_cnt_r <= CNT_W'(MUL_LAT - 1);
        end else if (mul_busy_s) begin
            mul_cnt_r <= mul_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mul_cnt_r <= mul_cnt_r;
        end
    end

    // Load-use tracker: remembers a just-accepted load's destination for one cycle only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ld_flag_r <= 1'b0;
            ld_rd_r   <= {RA_W{1'b0}};
        end else if (FLUSH) begin
            ld_flag_r <= 1'b0;
        end else if (accept_s) begin
            ld_flag_r <= is_load(op_s);
            ld_rd_r   <= RD;
        end else begin
            ld_flag_r <= 1'b0;
        end
    end

    assign IN_READY   = in_ready_s;
    assign OUT_VALID  = out_valid_r;
    assign RD_Q       = rd_r;
    assign ILLEGAL    = illegal_r;
    assign MUL_BUSY   = mul_busy_s;
    assign SEL_A      = word_r.sel_a;
    assign SEL_B      = word_r.sel_b;
    assign SEL_EXT    = word_r.sel_ext;
    assign SEL_RES    = word_r.sel_res;
    assign SEL_DAT    = word_r.sel_dat;
    assign SEL_C      = word_r.sel_c;
    assign SELOP_A    = word_r.selop_a;
    assign SELOP_B    = word_r.selop_b;
    assign ALU_CTRL   = ALU_W'(word_r.alu_ctrl);
    assign WE_MEM     = word_r.we_mem;
    assign WE_C_AUX   = word_r.we_c_aux;
    assign WE_V       = word_r.we_v;
    assign COMPARA    = word_r.compara;
    assign SUMA_RESTA = word_r.suma_resta;
    assign SALTO      = word_r.salto;
    assign PROHIB     = word_r.prohib;

endmodule
